// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: 64-bit data/address, single-ported-per-direction word array,
// independent write (AW/W/B) and read (AR/R) engines with one outstanding burst each.
module axi_mem_slave #(
   parameter int          ADDR_W = 12,
   parameter logic [63:0] BASE   = 64'h8000_0000,
   parameter int          ID_W   = 4
) (
   input  logic            sys_clk,
   input  logic            RST,
   input  logic [ID_W-1:0] S_AXI_AWID,
   input  logic [63:0]     S_AXI_AWADDR,
   input  logic [7:0]      S_AXI_AWLEN,
   input  logic [2:0]      S_AXI_AWSIZE,
   input  logic [1:0]      S_AXI_AWBURST,
   input  logic            S_AXI_AWLOCK,
   input  logic [3:0]      S_AXI_AWCACHE,
   input  logic [2:0]      S_AXI_AWPROT,
   input  logic            S_AXI_AWVALID,
   output logic            S_AXI_AWREADY,
   input  logic [63:0]     S_AXI_WDATA,
   input  logic [7:0]      S_AXI_WSTRB,
   input  logic            S_AXI_WLAST,
   input  logic            S_AXI_WVALID,
   output logic            S_AXI_WREADY,
   output logic [ID_W-1:0] S_AXI_BID,
   output logic [1:0]      S_AXI_BRESP,
   output logic            S_AXI_BVALID,
   input  logic            S_AXI_BREADY,
   input  logic [ID_W-1:0] S_AXI_ARID,
   input  logic [63:0]     S_AXI_ARADDR,
   input  logic [7:0]      S_AXI_ARLEN,
   input  logic [2:0]      S_AXI_ARSIZE,
   input  logic [1:0]      S_AXI_ARBURST,
   input  logic            S_AXI_ARLOCK,
   input  logic [3:0]      S_AXI_ARCACHE,
   input  logic [2:0]      S_AXI_ARPROT,
   input  logic            S_AXI_ARVALID,
   output logic            S_AXI_ARREADY,
   output logic [ID_W-1:0] S_AXI_RID,
   output logic [63:0]     S_AXI_RDATA,
   output logic [1:0]      S_AXI_RRESP,
   output logic            S_AXI_RLAST,
   output logic            S_AXI_RVALID,
   input  logic            S_AXI_RREADY,
   output logic [1:0]      w_state_dbg,
   output logic            r_state_dbg
);

   // Handshake rule on every channel: a transfer happens on the rising edge where
   // VALID and READY are both high; a raised VALID holds its payload until then.

   localparam int          DEPTH    = 1 << ADDR_W;
   localparam logic [63:0] SPAN     = 64'd8 << ADDR_W;
   localparam logic [1:0]  RESP_OK  = 2'b00;
   localparam logic [1:0]  RESP_SLV = 2'b10;
   localparam logic [1:0]  RESP_DEC = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   logic [63:0] mem [DEPTH];

   function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst);
      logic [63:0] step, mask;
      step = 64'd1 << size;
      mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~mask) | ((a + step) & mask);
         default: return a + step;
      endcase
   endfunction

   function automatic logic [1:0] burst_resp(input logic [1:0] burst, input logic [2:0] size,
                                             input logic [7:0] len);
      if (burst == 2'b11 || size > 3'd3) return RESP_SLV;
      if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         return RESP_SLV;
      return RESP_OK;
   endfunction

   // Addresses below BASE wrap to huge offsets, so one unsigned compare covers both sides.
   function automatic logic [1:0] dec_resp(input logic [63:0] a);
      return ((a - BASE) >= SPAN) ? RESP_DEC : RESP_OK;
   endfunction

   function automatic logic [ADDR_W-1:0] word_idx(input logic [63:0] a);
      return ADDR_W'((a - BASE) >> 3);
   endfunction

   // ---------------- write engine ----------------
   w_state_t        w_state;
   logic [ID_W-1:0] w_id;
   logic [63:0]     w_addr;
   logic [7:0]      w_len, w_cnt;
   logic [2:0]      w_size;
   logic [1:0]      w_burst, w_acc;
   logic            w_fire, w_last_beat, w_we;
   logic [1:0]      w_addr_resp, w_beat_resp;

   always_comb begin
      w_fire      = S_AXI_WVALID && S_AXI_WREADY;
      w_last_beat = (w_cnt == w_len);
      w_addr_resp = rmax(burst_resp(w_burst, w_size, w_len), dec_resp(w_addr));
      w_beat_resp = rmax(w_addr_resp, (S_AXI_WLAST != w_last_beat) ? RESP_SLV : RESP_OK);
      w_we        = w_fire && (w_addr_resp == RESP_OK);
   end

   always_ff @(posedge sys_clk or posedge RST) begin
      if (RST) begin
         w_state       <= W_IDLE;
         S_AXI_AWREADY <= 1'b1;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BID     <= '0;
         S_AXI_BRESP   <= RESP_OK;
         w_id          <= '0;
         w_addr        <= '0;
         w_len         <= '0;
         w_cnt         <= '0;
         w_size        <= '0;
         w_burst       <= '0;
         w_acc         <= RESP_OK;
      end else begin
         case (w_state)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_AWREADY) begin
               w_id          <= S_AXI_AWID;
               w_addr        <= S_AXI_AWADDR;
               w_len         <= S_AXI_AWLEN;
               w_size        <= S_AXI_AWSIZE;
               w_burst       <= S_AXI_AWBURST;
               w_cnt         <= '0;
               w_acc         <= RESP_OK;
               S_AXI_AWREADY <= 1'b0;
               S_AXI_WREADY  <= 1'b1;
               w_state       <= W_DATA;
            end
            W_DATA: if (w_fire) begin
               w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
               w_cnt  <= w_cnt + 8'd1;
               w_acc  <= rmax(w_acc, w_beat_resp);
               // The beat count, not WLAST, closes the burst.
               if (w_last_beat) begin
                  S_AXI_WREADY <= 1'b0;
                  S_AXI_BVALID <= 1'b1;
                  S_AXI_BID    <= w_id;
                  S_AXI_BRESP  <= rmax(w_acc, w_beat_resp);
                  w_state      <= W_RESP;
               end
            end
            W_RESP: if (S_AXI_BREADY) begin
               S_AXI_BVALID  <= 1'b0;
               S_AXI_AWREADY <= 1'b1;
               w_state       <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_we) begin
         for (int i = 0; i < 8; i++)
            if (S_AXI_WSTRB[i]) mem[word_idx(w_addr)][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
   end

   // ---------------- read engine ----------------
   r_state_t    r_state;
   logic [63:0] r_addr;
   logic [7:0]  r_len, r_cnt;
   logic [2:0]  r_size;
   logic [1:0]  r_burst;
   logic [63:0] ld_addr, ld_data;
   logic [7:0]  ld_len;
   logic [2:0]  ld_size;
   logic [1:0]  ld_burst, ld_resp;

   // The beat being loaded comes from AR in idle, otherwise from the stored next address.
   always_comb begin
      ld_addr  = (r_state == R_IDLE) ? S_AXI_ARADDR  : r_addr;
      ld_len   = (r_state == R_IDLE) ? S_AXI_ARLEN   : r_len;
      ld_size  = (r_state == R_IDLE) ? S_AXI_ARSIZE  : r_size;
      ld_burst = (r_state == R_IDLE) ? S_AXI_ARBURST : r_burst;
      ld_resp  = rmax(burst_resp(ld_burst, ld_size, ld_len), dec_resp(ld_addr));
      ld_data  = (ld_resp == RESP_OK) ? mem[word_idx(ld_addr)] : 64'd0;
   end

   always_ff @(posedge sys_clk or posedge RST) begin
      if (RST) begin
         r_state       <= R_IDLE;
         S_AXI_ARREADY <= 1'b1;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RLAST   <= 1'b0;
         S_AXI_RID     <= '0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OK;
         r_addr        <= '0;
         r_len         <= '0;
         r_cnt         <= '0;
         r_size        <= '0;
         r_burst       <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (S_AXI_ARVALID && S_AXI_ARREADY) begin
               S_AXI_RID     <= S_AXI_ARID;
               r_len         <= S_AXI_ARLEN;
               r_size        <= S_AXI_ARSIZE;
               r_burst       <= S_AXI_ARBURST;
               r_addr        <= next_addr(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARLEN, S_AXI_ARBURST);
               r_cnt         <= '0;
               S_AXI_RDATA   <= ld_data;
               S_AXI_RRESP   <= ld_resp;
               S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
               S_AXI_RVALID  <= 1'b1;
               S_AXI_ARREADY <= 1'b0;
               r_state       <= R_DATA;
            end
            R_DATA: if (S_AXI_RVALID && S_AXI_RREADY) begin
               if (S_AXI_RLAST) begin
                  S_AXI_RVALID  <= 1'b0;
                  S_AXI_RLAST   <= 1'b0;
                  S_AXI_ARREADY <= 1'b1;
                  r_state       <= R_IDLE;
               end else begin
                  S_AXI_RDATA <= ld_data;
                  S_AXI_RRESP <= ld_resp;
                  S_AXI_RLAST <= ((r_cnt + 8'd1) == r_len);
                  r_cnt       <= r_cnt + 8'd1;
                  r_addr      <= next_addr(r_addr, r_size, r_len, r_burst);
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign w_state_dbg = w_state;
   assign r_state_dbg = r_state;

   logic unused_sigs;
   assign unused_sigs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                          S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: directed and random bursts checked against a byte-level
// memory model that derives beat addresses and responses arithmetically.
module tb_axi_mem_slave;

   localparam int          ADDR_W = 12;
   localparam logic [63:0] BASE   = 64'h8000_0000;
   localparam logic [63:0] SPAN   = 64'd8 << ADDR_W;

   logic        sys_clk = 1'b0;
   logic        RST;
   logic [3:0]  S_AXI_AWID;
   logic [63:0] S_AXI_AWADDR;
   logic [7:0]  S_AXI_AWLEN;
   logic [2:0]  S_AXI_AWSIZE;
   logic [1:0]  S_AXI_AWBURST;
   logic        S_AXI_AWLOCK;
   logic [3:0]  S_AXI_AWCACHE;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID, S_AXI_AWREADY;
   logic [63:0] S_AXI_WDATA;
   logic [7:0]  S_AXI_WSTRB;
   logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
   logic [3:0]  S_AXI_BID;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID, S_AXI_BREADY;
   logic [3:0]  S_AXI_ARID;
   logic [63:0] S_AXI_ARADDR;
   logic [7:0]  S_AXI_ARLEN;
   logic [2:0]  S_AXI_ARSIZE;
   logic [1:0]  S_AXI_ARBURST;
   logic        S_AXI_ARLOCK;
   logic [3:0]  S_AXI_ARCACHE;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID, S_AXI_ARREADY;
   logic [3:0]  S_AXI_RID;
   logic [63:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
   logic [1:0]  w_state_dbg;
   logic        r_state_dbg;

   axi_mem_slave #(.ADDR_W(ADDR_W), .BASE(BASE), .ID_W(4)) dut (
      .sys_clk(sys_clk), .RST(RST),
      .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
      .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
      .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
      .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
      .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
      .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
   );

   always #5 sys_clk = ~sys_clk;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] ref_mem [int];
   logic [63:0] wdata_q [$];
   logic [7:0]  wstrb_q [$];
   logic [63:0] exp_q [$];
   logic [1:0]  expr_q [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: beat i address computed directly from the burst rules.
   function automatic logic [63:0] beat_addr(input logic [63:0] a0, input int i, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst);
      logic [63:0] step, wb, lo;
      step = 64'd1 << size;
      if (burst == 2'b00) return a0;
      if (burst == 2'b10) begin
         wb = (64'(len) + 64'd1) * step;
         lo = a0 - (a0 % wb);
         return lo + ((a0 - lo) + 64'(i) * step) % wb;
      end
      return a0 + 64'(i) * step;
   endfunction

   function automatic logic [1:0] beat_resp(input logic [63:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
      logic [1:0] r;
      r = 2'b00;
      if (burst == 2'b11 || size > 3'd3 ||
          (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)))
         r = 2'b10;
      if (a < BASE || a >= BASE + SPAN) r = 2'b11;
      return r;
   endfunction

   function automatic int word_of(input logic [63:0] a);
      return int'((a - BASE) / 64'd8);
   endfunction

   task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      @(negedge sys_clk);
      S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
      S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
      n = 0;
      while (!S_AXI_AWREADY && n < 50) begin @(negedge sys_clk); n++; end
      check("aw_accept", 64'(n < 50), 64'd1);
      @(negedge sys_clk);
      S_AXI_AWVALID = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n;
      S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 50) begin @(negedge sys_clk); n++; end
      check("w_accept", 64'(n < 50), 64'd1);
      @(negedge sys_clk);
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
   endtask

   // wlast_mode 0: WLAST on the final beat; 1: WLAST never asserted.
   task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int wlast_mode);
      logic [1:0]  exp_b, r;
      logic [63:0] a, m;
      int          n, w;
      exp_b = 2'b00;
      for (int i = 0; i <= int'(len); i++) begin
         a = beat_addr(addr, i, size, len, burst);
         r = beat_resp(a, size, len, burst);
         if (r > exp_b) exp_b = r;
         if (r == 2'b00) begin
            w = word_of(a);
            m = ref_mem.exists(w) ? ref_mem[w] : 64'd0;
            for (int b = 0; b < 8; b++)
               if (wstrb_q[i][b]) m[8*b +: 8] = wdata_q[i][8*b +: 8];
            ref_mem[w] = m;
         end
      end
      if (wlast_mode == 1 && exp_b < 2'b10) exp_b = 2'b10;
      send_aw(id, addr, len, size, burst);
      for (int i = 0; i <= int'(len); i++)
         send_w(wdata_q[i], wstrb_q[i], (wlast_mode == 0) && (i == int'(len)));
      n = 0;
      while (!S_AXI_BVALID && n < 50) begin @(negedge sys_clk); n++; end
      check("bvalid_seen", 64'(n < 50), 64'd1);
      check("bid", 64'(S_AXI_BID), 64'(id));
      check("bresp", 64'(S_AXI_BRESP), 64'(exp_b));
      S_AXI_BREADY = 1'b1;
      @(negedge sys_clk);
      S_AXI_BREADY = 1'b0;
      check("bvalid_clear", 64'(S_AXI_BVALID), 64'd0);
      wdata_q.delete(); wstrb_q.delete();
   endtask

   // mode 0: RREADY always high; 1: RREADY 1010...; 2: random RREADY.
   task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode,
                          output int gaps);
      logic [63:0] a, hold_d;
      logic [1:0]  r;
      logic        hold_l, have_hold;
      int          n, k, cyc;
      for (int i = 0; i <= int'(len); i++) begin
         a = beat_addr(addr, i, size, len, burst);
         r = beat_resp(a, size, len, burst);
         exp_q.push_back((r == 2'b00) ? ref_mem[word_of(a)] : 64'd0);
         expr_q.push_back(r);
      end
      @(negedge sys_clk);
      S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
      S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!S_AXI_ARREADY && n < 50) begin @(negedge sys_clk); n++; end
      check("ar_accept", 64'(n < 50), 64'd1);
      @(negedge sys_clk);
      S_AXI_ARVALID = 1'b0;
      k = 0; cyc = 0; gaps = 0; have_hold = 1'b0; hold_d = '0; hold_l = 1'b0;
      while (k <= int'(len) && cyc < 300) begin
         S_AXI_RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         if (have_hold) begin
            check("r_hold_valid", 64'(S_AXI_RVALID), 64'd1);
            check("r_hold_data", S_AXI_RDATA, hold_d);
            check("r_hold_last", 64'(S_AXI_RLAST), 64'(hold_l));
            have_hold = 1'b0;
         end
         if (S_AXI_RVALID) begin
            if (S_AXI_RREADY) begin
               check("rdata", S_AXI_RDATA, exp_q.pop_front());
               check("rresp", 64'(S_AXI_RRESP), 64'(expr_q.pop_front()));
               check("rlast", 64'(S_AXI_RLAST), 64'(k == int'(len)));
               check("rid", 64'(S_AXI_RID), 64'(id));
               k++;
            end else begin
               hold_d = S_AXI_RDATA; hold_l = S_AXI_RLAST; have_hold = 1'b1;
            end
         end else if (k > 0) gaps++;
         @(negedge sys_clk);
         cyc++;
      end
      S_AXI_RREADY = 1'b0;
      check("r_beats", 64'(k), 64'(int'(len) + 1));
      check("r_end_valid", 64'(S_AXI_RVALID), 64'd0);
      exp_q.delete(); expr_q.delete();
   endtask

   task automatic fill(input int beats, input logic [7:0] strb);
      for (int i = 0; i < beats; i++) begin
         wdata_q.push_back({$urandom, $urandom});
         wstrb_q.push_back(strb);
      end
   endtask

   initial begin
      int          gaps;
      logic [63:0] a0, d0, d1, ra;
      logic [7:0]  rl;
      logic [2:0]  rs;
      logic [1:0]  rb;
      RST = 1'b1;
      S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0;
      S_AXI_AWLOCK = 1'b0; S_AXI_AWCACHE = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0; S_AXI_ARBURST = '0;
      S_AXI_ARLOCK = 1'b0; S_AXI_ARCACHE = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      repeat (3) @(negedge sys_clk);
      RST = 1'b0;

      check("rst_awready", 64'(S_AXI_AWREADY), 64'd1);
      check("rst_arready", 64'(S_AXI_ARREADY), 64'd1);
      check("rst_wready", 64'(S_AXI_WREADY), 64'd0);
      check("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
      check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
      check("rst_rlast", 64'(S_AXI_RLAST), 64'd0);
      check("rst_bid", 64'(S_AXI_BID), 64'd0);
      check("rst_bresp", 64'(S_AXI_BRESP), 64'd0);
      check("rst_rid", 64'(S_AXI_RID), 64'd0);
      check("rst_rdata", S_AXI_RDATA, 64'd0);
      check("rst_rresp", 64'(S_AXI_RRESP), 64'd0);

      // Basic 4-beat INCR write then full-throughput readback.
      wdata_q = '{64'h11, 64'h22, 64'h33, 64'h44};
      wstrb_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      do_write(4'h5, BASE, 8'd3, 3'd3, 2'b01, 0);
      do_read(4'h6, BASE, 8'd3, 3'd3, 2'b01, 0, gaps);
      check("r_gaps", 64'(gaps), 64'd0);

      // 8-beat read with RREADY toggling 1010.
      fill(8, 8'hFF);
      do_write(4'h1, BASE + 64'h100, 8'd7, 3'd3, 2'b01, 0);
      do_read(4'h2, BASE + 64'h100, 8'd7, 3'd3, 2'b01, 1, gaps);

      // Byte strobes merge into an existing word.
      wdata_q = '{64'h1111_2222_3333_4444}; wstrb_q = '{8'hFF};
      do_write(4'h3, BASE + 64'h200, 8'd0, 3'd3, 2'b01, 0);
      wdata_q = '{64'hAAAA_AAAA_BBBB_BBBB}; wstrb_q = '{8'h0F};
      do_write(4'h3, BASE + 64'h200, 8'd0, 3'd3, 2'b01, 0);
      do_read(4'h4, BASE + 64'h200, 8'd0, 3'd3, 2'b01, 0, gaps);

      // WRAP starting at +0x18 lands beats at 0x18,0x00,0x08,0x10.
      fill(4, 8'hFF);
      do_write(4'h7, BASE + 64'h18, 8'd3, 3'd3, 2'b10, 0);
      do_read(4'h8, BASE, 8'd3, 3'd3, 2'b01, 0, gaps);
      do_read(4'h9, BASE + 64'h18, 8'd3, 3'd3, 2'b10, 2, gaps);

      // Decode errors, missing WLAST and illegal burst encodings.
      do_read(4'hA, BASE + SPAN, 8'd1, 3'd3, 2'b01, 0, gaps);
      fill(1, 8'hFF);
      do_write(4'hB, BASE + SPAN - 64'd8, 8'd0, 3'd3, 2'b01, 0);
      fill(1, 8'hFF);
      do_write(4'hC, BASE - 64'd8, 8'd0, 3'd3, 2'b01, 0);
      do_read(4'hC, BASE + SPAN - 64'd8, 8'd0, 3'd3, 2'b01, 0, gaps);
      fill(3, 8'hFF);
      do_write(4'hD, BASE + 64'h400, 8'd2, 3'd3, 2'b01, 1);
      fill(2, 8'hFF);
      do_write(4'hE, BASE + 64'h500, 8'd1, 3'd3, 2'b11, 0);
      do_read(4'hE, BASE + 64'h500, 8'd1, 3'd3, 2'b11, 0, gaps);
      fill(3, 8'hFF);
      do_write(4'hF, BASE + 64'h600, 8'd2, 3'd3, 2'b10, 0);

      // Reset in the middle of a 4-beat write: only beats 0-1 land.
      a0 = BASE + 64'h1000;
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      send_aw(4'h9, a0, 8'd3, 3'd3, 2'b01);
      send_w(d0, 8'hFF, 1'b0);
      send_w(d1, 8'hFF, 1'b0);
      S_AXI_WDATA = {$urandom, $urandom}; S_AXI_WSTRB = 8'hFF; S_AXI_WVALID = 1'b1;
      #2 RST = 1'b1;
      #1;
      check("mid_awready", 64'(S_AXI_AWREADY), 64'd1);
      check("mid_wready", 64'(S_AXI_WREADY), 64'd0);
      check("mid_bvalid", 64'(S_AXI_BVALID), 64'd0);
      check("mid_bresp", 64'(S_AXI_BRESP), 64'd0);
      check("mid_bid", 64'(S_AXI_BID), 64'd0);
      check("mid_rvalid", 64'(S_AXI_RVALID), 64'd0);
      @(negedge sys_clk);
      S_AXI_WVALID = 1'b0;
      RST = 1'b0;
      ref_mem[word_of(a0)] = d0;
      ref_mem[word_of(a0) + 1] = d1;
      fill(1, 8'hFF);
      do_write(4'h2, BASE + 64'h1100, 8'd0, 3'd3, 2'b01, 0);
      do_read(4'h3, a0, 8'd1, 3'd3, 2'b01, 0, gaps);

      // Random in-range bursts, full strobes, random RREADY.
      for (int t = 0; t < 20; t++) begin
         rb = 2'($urandom_range(0, 2));
         rs = 3'($urandom_range(0, 3));
         if (rb == 2'b10) rl = 8'((1 << $urandom_range(1, 4)) - 1);
         else rl = 8'($urandom_range(0, 15));
         ra = BASE + 64'($urandom_range(0, 4000)) * 64'd8
              + (64'($urandom_range(0, 7)) & ~((64'd1 << rs) - 64'd1));
         fill(int'(rl) + 1, 8'hFF);
         do_write(4'($urandom_range(0, 15)), ra, rl, rs, rb, 0);
         do_read(4'($urandom_range(0, 15)), ra, rl, rs, rb, 2, gaps);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
